pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 30 +++
 rtl/pipe_stage.sv | 108 ++++++++++
 tb/tb_pipe_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the pipe_stage skid-buffer slice.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones and only reset clears it.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    count_d = count_q;
    if (inc) count_d = sat_inc(count_q);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage with a skid register so in_ready is fully registered.
// Define PIPE_STAT_EN to add the stall_cnt / bubble_cnt statistics ports.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_msg
`ifdef PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage: WIDTH and CNT_W must be positive");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != FULL) & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign out_msg   = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_msg;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b11: main_d = in_msg;
          2'b10: begin
            state_d = FULL;
            skid_d  = in_msg;
          end
          2'b01: state_d = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over both handshakes; the accepted input is simply dropped.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: a queue model of the two-entry stage predicts
// every output; stats checks are compiled in when PIPE_STAT_EN is defined.
module tb_pipe_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_msg = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_msg;
`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_msg    (in_msg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_msg   (out_msg)
`ifdef PIPE_STAT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  typedef struct packed {
    logic             rst;
    logic             fl;
    logic             iv;
    logic             ordy;
    logic [WIDTH-1:0] msg;
  } stim_t;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] idle_msg = '0;
  int               stall_m = 0;
  int               bubble_m = 0;
  int               n_checks = 0;
  int               n_fail = 0;

  function automatic stim_t s(input logic rst, input logic fl, input logic iv,
                              input logic ordy, input logic [WIDTH-1:0] msg);
    stim_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.ordy = ordy; r.msg = msg;
    return r;
  endfunction

  // Drive one cycle of stimulus and advance the reference model across the next edge.
  task automatic apply(input stim_t st);
    logic ofire, ifire;
    reset = st.rst; flush = st.fl; in_valid = st.iv; out_ready = st.ordy; in_msg = st.msg;
    if (st.rst) begin
      exp_q.delete();
      idle_msg = '0;
      stall_m = 0;
      bubble_m = 0;
    end else begin
      if (exp_q.size() > 0 && !st.ordy && stall_m < CNT_MAX) stall_m++;
      if (exp_q.size() == 0 && bubble_m < CNT_MAX) bubble_m++;
      if (st.fl) begin
        exp_q.delete();
        idle_msg = '0;
      end else begin
        ofire = st.ordy && (exp_q.size() > 0);
        ifire = st.iv && (exp_q.size() < 2);
        if (ofire) idle_msg = exp_q.pop_front();
        if (ifire) exp_q.push_back(st.msg);
      end
    end
  endtask

  task automatic test_reset();
    stim_t sq[$];
    logic exp_vld, exp_rdy;
    logic [WIDTH-1:0] exp_msg;
    apply(s(1, 0, 1, 1, 32'h55));
    sq.push_back(s(1, 0, 1, 1, 32'h66));
    sq.push_back(s(0, 0, 0, 0, 0));
    sq.push_back(s(0, 0, 0, 0, 0));
    foreach (sq[i]) begin
      @(negedge clk);
      exp_vld = exp_q.size() > 0;
      exp_msg = exp_vld ? exp_q[0] : idle_msg;
      exp_rdy = !reset && exp_q.size() < 2;
      n_checks += 3;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL reset in_ready cyc %0d: got %b want %b", i, in_ready, exp_rdy); end
      if (out_valid !== exp_vld) begin n_fail++; $display("FAIL reset out_valid cyc %0d: got %b want %b", i, out_valid, exp_vld); end
      if (out_msg !== exp_msg) begin n_fail++; $display("FAIL reset out_msg cyc %0d: got %h want %h", i, out_msg, exp_msg); end
`ifdef PIPE_STAT_EN
      if (reset) begin
        n_checks += 2;
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset stall_cnt: got %h want 0", stall_cnt); end
        if (bubble_cnt !== '0) begin n_fail++; $display("FAIL reset bubble_cnt: got %h want 0", bubble_cnt); end
      end
`endif
      apply(sq[i]);
    end
  endtask

  task automatic test_stream();
    stim_t sq[$];
    logic exp_vld, exp_rdy;
    logic [WIDTH-1:0] exp_msg;
    sq.push_back(s(0, 0, 1, 1, 32'h11));
    sq.push_back(s(0, 0, 1, 1, 32'h22));
    sq.push_back(s(0, 0, 1, 1, 32'h33));
    sq.push_back(s(0, 0, 0, 1, 0));
    sq.push_back(s(0, 0, 0, 1, 0));
    sq.push_back(s(0, 0, 0, 1, 0));
    foreach (sq[i]) begin
      @(negedge clk);
      exp_vld = exp_q.size() > 0;
      exp_msg = exp_vld ? exp_q[0] : idle_msg;
      exp_rdy = !reset && exp_q.size() < 2;
      n_checks += 3;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL stream in_ready cyc %0d: got %b want %b", i, in_ready, exp_rdy); end
      if (out_valid !== exp_vld) begin n_fail++; $display("FAIL stream out_valid cyc %0d: got %b want %b", i, out_valid, exp_vld); end
      if (out_msg !== exp_msg) begin n_fail++; $display("FAIL stream out_msg cyc %0d: got %h want %h", i, out_msg, exp_msg); end
      apply(sq[i]);
    end
    // Last payload must stay visible in main after draining to EMPTY.
    n_checks++;
    if (out_msg !== 32'h33) begin n_fail++; $display("FAIL stream retain: got %h want 00000033", out_msg); end
  endtask

  task automatic test_backpressure();
    stim_t sq[$];
    logic exp_vld, exp_rdy;
    logic [WIDTH-1:0] exp_msg;
    sq.push_back(s(0, 0, 1, 0, 32'hA));
    sq.push_back(s(0, 0, 1, 0, 32'hB));
    sq.push_back(s(0, 0, 1, 0, 32'hC));
    sq.push_back(s(0, 0, 0, 1, 0));
    sq.push_back(s(0, 0, 0, 1, 0));
    sq.push_back(s(0, 0, 0, 1, 0));
    foreach (sq[i]) begin
      @(negedge clk);
      exp_vld = exp_q.size() > 0;
      exp_msg = exp_vld ? exp_q[0] : idle_msg;
      exp_rdy = !reset && exp_q.size() < 2;
      n_checks += 3;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp in_ready cyc %0d: got %b want %b", i, in_ready, exp_rdy); end
      if (out_valid !== exp_vld) begin n_fail++; $display("FAIL bp out_valid cyc %0d: got %b want %b", i, out_valid, exp_vld); end
      if (out_msg !== exp_msg) begin n_fail++; $display("FAIL bp out_msg cyc %0d: got %h want %h", i, out_msg, exp_msg); end
      if (i == 2) begin
        n_checks += 2;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp full_ready: got %b want 0", in_ready); end
        if (out_msg !== 32'hA) begin n_fail++; $display("FAIL bp full_head: got %h want 0000000a", out_msg); end
      end
      apply(sq[i]);
    end
  endtask

  task automatic test_flush_collision();
    stim_t sq[$];
    logic exp_vld, exp_rdy;
    logic [WIDTH-1:0] exp_msg;
    sq.push_back(s(0, 0, 1, 0, 32'hA));
    sq.push_back(s(0, 0, 1, 0, 32'hB));
    sq.push_back(s(0, 1, 1, 1, 32'hC));
    for (int k = 0; k < 4; k++) sq.push_back(s(0, 0, 0, 1, 0));
    foreach (sq[i]) begin
      @(negedge clk);
      exp_vld = exp_q.size() > 0;
      exp_msg = exp_vld ? exp_q[0] : idle_msg;
      exp_rdy = !reset && exp_q.size() < 2;
      n_checks += 3;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL flush in_ready cyc %0d: got %b want %b", i, in_ready, exp_rdy); end
      if (out_valid !== exp_vld) begin n_fail++; $display("FAIL flush out_valid cyc %0d: got %b want %b", i, out_valid, exp_vld); end
      if (out_msg !== exp_msg) begin n_fail++; $display("FAIL flush out_msg cyc %0d: got %h want %h", i, out_msg, exp_msg); end
      apply(sq[i]);
    end
  endtask

  task automatic test_reset_full();
    stim_t sq[$];
    logic exp_vld, exp_rdy;
    logic [WIDTH-1:0] exp_msg;
    sq.push_back(s(0, 0, 1, 0, 32'hA));
    sq.push_back(s(0, 0, 1, 0, 32'hB));
    sq.push_back(s(1, 1, 1, 1, 32'hD));
    for (int k = 0; k < 4; k++) sq.push_back(s(0, 0, 0, 1, 0));
    foreach (sq[i]) begin
      @(negedge clk);
      exp_vld = exp_q.size() > 0;
      exp_msg = exp_vld ? exp_q[0] : idle_msg;
      exp_rdy = !reset && exp_q.size() < 2;
      n_checks += 3;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rstfull in_ready cyc %0d: got %b want %b", i, in_ready, exp_rdy); end
      if (out_valid !== exp_vld) begin n_fail++; $display("FAIL rstfull out_valid cyc %0d: got %b want %b", i, out_valid, exp_vld); end
      if (out_msg !== exp_msg) begin n_fail++; $display("FAIL rstfull out_msg cyc %0d: got %h want %h", i, out_msg, exp_msg); end
      apply(sq[i]);
    end
  endtask

`ifdef PIPE_STAT_EN
  task automatic test_stats();
    stim_t sq[$];
    logic exp_vld;
    logic [WIDTH-1:0] exp_msg;
    sq.push_back(s(0, 0, 1, 0, 32'h77));
    for (int k = 0; k < 20; k++) sq.push_back(s(0, 0, 0, 0, 0));
    sq.push_back(s(0, 1, 0, 0, 0));
    sq.push_back(s(0, 0, 0, 0, 0));
    sq.push_back(s(0, 0, 0, 0, 0));
    foreach (sq[i]) begin
      @(negedge clk);
      exp_vld = exp_q.size() > 0;
      exp_msg = exp_vld ? exp_q[0] : idle_msg;
      n_checks += 4;
      if (out_valid !== exp_vld) begin n_fail++; $display("FAIL stats out_valid cyc %0d: got %b want %b", i, out_valid, exp_vld); end
      if (out_msg !== exp_msg) begin n_fail++; $display("FAIL stats out_msg cyc %0d: got %h want %h", i, out_msg, exp_msg); end
      if (stall_cnt !== CNT_W'(stall_m)) begin n_fail++; $display("FAIL stats stall_cnt cyc %0d: got %h want %h", i, stall_cnt, stall_m); end
      if (bubble_cnt !== CNT_W'(bubble_m)) begin n_fail++; $display("FAIL stats bubble_cnt cyc %0d: got %h want %h", i, bubble_cnt, bubble_m); end
      apply(sq[i]);
    end
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL stats stall_sat: got %h want f", stall_cnt); end
  endtask
`endif

  task automatic test_back_to_back();
    stim_t st;
    logic exp_vld, exp_rdy;
    logic [WIDTH-1:0] exp_msg;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      exp_vld = exp_q.size() > 0;
      exp_msg = exp_vld ? exp_q[0] : idle_msg;
      exp_rdy = !reset && exp_q.size() < 2;
      n_checks += 3;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b in_ready cyc %0d: got %b want %b", i, in_ready, exp_rdy); end
      if (out_valid !== exp_vld) begin n_fail++; $display("FAIL b2b out_valid cyc %0d: got %b want %b", i, out_valid, exp_vld); end
      if (out_msg !== exp_msg) begin n_fail++; $display("FAIL b2b out_msg cyc %0d: got %h want %h", i, out_msg, exp_msg); end
      st = s(0, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
             ($urandom_range(0, 99) < 60), WIDTH'($urandom));
      apply(st);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_collision();
    test_reset_full();
`ifdef PIPE_STAT_EN
    test_stats();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
